// File: rtl/ctrl_mem_pkg.sv
// ctrl_mem_pkg: shared widths, command encodings and FSM state encoding for ctrl_mem_ula
package ctrl_mem_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam logic CMD_LOAD = 1'b0;
  localparam logic CMD_OP   = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/ctrl_mem_ula.sv
// ctrl_mem_ula: command controller sequencing LOAD writes and ALU OPs on a memory/ALU datapath
// Ports: clk/rst (async active-high); cmd_* request with cmd_ready handshake;
//   s_ula ALU result in; cs/we_mem_in/we_resultado strobes, enderecoA/B/endereco_saida,
//   dado_in, opcode to the datapath; done pulse, res_data last result, cmd_count completions.
module ctrl_mem_ula
  import ctrl_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_kind,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_addr_dst,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] s_ula,
  output logic              cs,
  output logic              we_mem_in,
  output logic              we_resultado,
  output logic [ADDR_W-1:0] enderecoA,
  output logic [ADDR_W-1:0] enderecoB,
  output logic [ADDR_W-1:0] endereco_saida,
  output logic [DATA_W-1:0] dado_in,
  output logic [OP_W-1:0]   opcode,
  output logic              done,
  output logic [DATA_W-1:0] res_data,
  output logic [7:0]        cmd_count
);
  state_t            r_state, w_next;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_a, r_b, r_dst;
  logic [DATA_W-1:0] r_data, r_res;
  logic [7:0]        r_count;
  logic              w_accept, w_rd;
  assign cmd_ready = !rst && r_state == S_IDLE;
  assign w_accept  = cmd_valid && cmd_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = !w_accept ? S_IDLE : (cmd_kind == CMD_LOAD ? S_LOAD : S_READ);
      S_LOAD:  w_next = S_DONE;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // command fields only move on acceptance, so mid-command changes on cmd_* are invisible
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_dst  <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_op   <= cmd_opcode;
      r_a    <= cmd_addr_a;
      r_b    <= cmd_addr_b;
      r_dst  <= cmd_addr_dst;
      r_data <= cmd_data;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_res   <= '0;
      r_count <= '0;
    end else begin
      if (r_state == S_EXEC) r_res <= s_ula;
      if (r_state == S_DONE) r_count <= r_count + 8'd1;
    end
  // the datapath has one cycle of read latency, so A/B/opcode are presented from READ through WRITE
  always_comb begin
    w_rd           = r_state inside {S_READ, S_EXEC, S_WRITE};
    cs             = r_state != S_IDLE;
    we_mem_in      = r_state == S_LOAD;
    we_resultado   = r_state == S_WRITE;
    done           = r_state == S_DONE;
    enderecoA      = w_rd ? r_a : '0;
    enderecoB      = w_rd ? r_b : '0;
    opcode         = w_rd ? r_op : '0;
    endereco_saida = r_state inside {S_LOAD, S_WRITE} ? r_dst : '0;
    dado_in        = r_state == S_LOAD ? r_data : '0;
    res_data       = r_res;
    cmd_count      = r_count;
  end
endmodule

// File: tb/tb_ctrl_mem_ula.sv
// tb_ctrl_mem_ula: randomized and directed self-checking bench for ctrl_mem_ula
module tb_ctrl_mem_ula;
  logic       clk, rst, cmd_valid, cmd_ready, cmd_kind;
  logic [2:0] cmd_opcode, opcode;
  logic [8:0] cmd_addr_a, cmd_addr_b, cmd_addr_dst, enderecoA, enderecoB, endereco_saida;
  logic [7:0] cmd_data, s_ula, dado_in, res_data, cmd_count;
  logic       cs, we_mem_in, we_resultado, done;
  int         checks = 0, errors = 0, cyc = 0, last_acc = -1, last_len = 0;
  logic [7:0] m_count = 0, m_res = 0;

  ctrl_mem_ula dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_opcode(cmd_opcode), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
    .cmd_addr_dst(cmd_addr_dst), .cmd_data(cmd_data), .s_ula(s_ula), .cs(cs),
    .we_mem_in(we_mem_in), .we_resultado(we_resultado), .enderecoA(enderecoA),
    .enderecoB(enderecoB), .endereco_saida(endereco_saida), .dado_in(dado_in),
    .opcode(opcode), .done(done), .res_data(res_data), .cmd_count(cmd_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst) begin
      checks++;
      assert (!(we_mem_in && we_resultado)) else begin
        errors++;
        $error("FAIL we_excl mem=%0b res=%0b", we_mem_in, we_resultado);
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic junk(input logic hold);
    cmd_valid    = hold;
    cmd_kind     = 1'($urandom);
    cmd_opcode   = 3'($urandom);
    cmd_addr_a   = 9'($urandom);
    cmd_addr_b   = 9'($urandom);
    cmd_addr_dst = 9'($urandom);
    cmd_data     = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cmd_valid = 0;
      chk("idle_rdy", cmd_ready, 1);
      chk("idle_cnt", cmd_count, m_count);
    end
    last_acc = -1;
  endtask

  // Expected behaviour per command: LOAD = write cycle then done; OP = two read cycles,
  // result write cycle, then done. Back-to-back accepts are spaced by command length + 1.
  task automatic issue(input logic kind, input logic [2:0] op, input logic [8:0] a, b, dst,
                       input logic [7:0] data, sula, input logic hold);
    int len = kind ? 4 : 2;
    @(negedge clk);
    chk("ready", cmd_ready, 1);
    chk("idle_cs", cs, 0);
    chk("idle_done", done, 0);
    chk("count", cmd_count, m_count);
    chk("res_hold", res_data, m_res);
    if (last_acc >= 0) chk("spacing", cyc - last_acc, last_len + 1);
    last_acc = cyc;
    last_len = len;
    cmd_valid = 1; cmd_kind = kind; cmd_opcode = op; cmd_addr_a = a; cmd_addr_b = b;
    cmd_addr_dst = dst; cmd_data = data; s_ula = 8'($urandom);
    @(negedge clk);
    junk(hold);
    if (!kind) begin
      chk("ld_cs", cs, 1);
      chk("ld_we", we_mem_in, 1);
      chk("ld_wr", we_resultado, 0);
      chk("ld_dst", endereco_saida, dst);
      chk("ld_data", dado_in, data);
      chk("ld_done", done, 0);
      chk("ld_rdy", cmd_ready, 0);
      @(negedge clk);
      junk(hold);
    end else begin
      for (int k = 1; k <= 2; k++) begin
        chk("rd_cs", cs, 1);
        chk("rd_a", enderecoA, a);
        chk("rd_b", enderecoB, b);
        chk("rd_op", opcode, op);
        chk("rd_we", {we_mem_in, we_resultado}, 0);
        chk("rd_done", done, 0);
        if (k == 2) s_ula = sula;
        @(negedge clk);
        junk(hold);
      end
      s_ula = 8'($urandom);
      m_res = sula;
      chk("wr_we", we_resultado, 1);
      chk("wr_dst", endereco_saida, dst);
      chk("wr_a", enderecoA, a);
      chk("wr_b", enderecoB, b);
      chk("wr_op", opcode, op);
      chk("wr_res", res_data, sula);
      chk("wr_done", done, 0);
      @(negedge clk);
      junk(hold);
    end
    chk("done", done, 1);
    chk("done_cs", cs, 1);
    chk("done_we", {we_mem_in, we_resultado}, 0);
    chk("done_cnt", cmd_count, m_count);
    m_count++;
  endtask

  function automatic logic [8:0] raddr();
    int r = $urandom_range(0, 3);
    return r == 0 ? 9'h000 : r == 1 ? 9'h1FF : 9'($urandom);
  endfunction

  initial begin
    rst = 1; cmd_valid = 1; cmd_kind = 0; cmd_opcode = 0; cmd_addr_a = 0; cmd_addr_b = 0;
    cmd_addr_dst = 0; cmd_data = 8'hAA; s_ula = 0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", cmd_ready, 0);
    chk("rst_cs", cs, 0);
    chk("rst_we", {we_mem_in, we_resultado, done}, 0);
    chk("rst_addr", {enderecoA, enderecoB, endereco_saida}, 0);
    chk("rst_data", {dado_in, opcode, res_data, cmd_count}, 0);
    rst = 0; cmd_valid = 0;
    #1 chk("rst_rel_rdy", cmd_ready, 1);
    issue(0, 3'd0, 9'h000, 9'h000, 9'h001, 8'h04, 8'h00, 0);
    issue(1, 3'd0, 9'h008, 9'h009, 9'h002, 8'h00, 8'h0C, 0);
    issue(0, 3'd0, 9'h000, 9'h000, 9'h1FF, 8'hFF, 8'h00, 0);
    issue(1, 3'd7, 9'h000, 9'h1FF, 9'h1FF, 8'h00, 8'hA5, 0);
    for (int i = 0; i < 6; i++)
      issue(1'(i), 3'($urandom), raddr(), raddr(), raddr(), 8'($urandom), 8'($urandom), 1);
    idle(2);
    for (int i = 0; i < 20; i++)
      issue(1'($urandom), 3'($urandom), raddr(), raddr(), raddr(), 8'($urandom), 8'($urandom),
            1'($urandom));
    idle(1);
    // abort an OP in its WRITE cycle
    @(negedge clk);
    cmd_valid = 1; cmd_kind = 1; cmd_opcode = 3'd3; cmd_addr_a = 9'h011; cmd_addr_b = 9'h022;
    cmd_addr_dst = 9'h033;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    s_ula = 8'h5A;
    @(negedge clk);
    chk("ab_wr", we_resultado, 1);
    #2 rst = 1;
    #1 chk("ab_drop", we_resultado, 0);
    chk("ab_cs", cs, 0);
    chk("ab_rdy", cmd_ready, 0);
    chk("ab_dst", endereco_saida, 0);
    @(negedge clk);
    chk("ab_done", done, 0);
    chk("ab_cnt", cmd_count, 0);
    @(negedge clk);
    chk("ab_done2", done, 0);
    rst = 0;
    #1 chk("ab_rdy_rel", cmd_ready, 1);
    chk("ab_res", res_data, 0);
    m_count = 0; m_res = 0; last_acc = -1;
    issue(1, 3'd5, 9'h044, 9'h055, 9'h066, 8'h00, 8'h3C, 0);
    // wrap of the completion counter
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_count = 0; m_res = 0; last_acc = -1;
    for (int i = 0; i < 256; i++)
      issue(0, 3'd0, 9'h000, 9'h000, 9'($urandom), 8'($urandom), 8'h00, 1);
    idle(1);
    chk("wrap", cmd_count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_mem_ula.md
CTRL_MEM_ULA -- requirements
Module: ctrl_mem_ula

Interface
REQ-001 The block SHALL have exactly one clock and one asynchronous, active-high reset, with the ports listed below.
REQ-002 clk  in  1  rising-edge clock; single clock domain.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  controller accepts a command this cycle.
REQ-006 cmd_kind  in  1  0 = LOAD (write cmd_data to memory), 1 = OP (ALU operation).
REQ-007 cmd_opcode  in  3  ALU opcode for OP commands.
REQ-008 cmd_addr_a, cmd_addr_b  in  9 each  operand addresses for OP commands.
REQ-009 cmd_addr_dst  in  9  destination address for both LOAD and OP commands.
REQ-010 cmd_data  in  8  LOAD data.
REQ-011 s_ula  in  8  ALU result returned by the memory/ALU datapath.
REQ-012 cs, we_mem_in, we_resultado  out  1 each  datapath control strobes.
REQ-013 enderecoA, enderecoB, endereco_saida  out  9 each  datapath addresses.
REQ-014 dado_in  out  8  LOAD data driven to the datapath.
REQ-015 opcode  out  3  ALU opcode driven to the datapath.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 res_data  out  8  last captured ALU result.
REQ-018 cmd_count  out  8  number of completed commands, wrapping.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, LOAD, READ, EXEC, WRITE and DONE; each non-IDLE state SHALL last exactly one cycle.
REQ-020 cmd_ready SHALL be 1 only in IDLE while rst=0; a command is accepted on a clk edge where cmd_valid=1 and cmd_ready=1, and all cmd_* fields are latched on that edge.
REQ-021 On acceptance, IDLE SHALL go to LOAD if cmd_kind=0, else to READ; with no acceptance, IDLE SHALL remain in IDLE.
REQ-022 The FSM SHALL step LOAD->DONE, READ->EXEC->WRITE->DONE, and DONE->IDLE.
REQ-023 cs SHALL be 1 in every state except IDLE.
REQ-024 LOAD: we_mem_in=1, endereco_saida=latched dst, dado_in=latched data.
REQ-025 READ and EXEC: enderecoA/enderecoB=latched a/b, opcode=latched opcode, both write enables 0 (one cycle of datapath read latency).
REQ-026 The block SHALL capture s_ula into res_data on the edge leaving EXEC.
REQ-027 WRITE: we_resultado=1, endereco_saida=latched dst, addresses A/B and opcode held.
REQ-028 DONE: done=1 for exactly one cycle, and cmd_count SHALL increment on the edge leaving DONE, wrapping 255->0.
REQ-029 Latency: with a LOAD accepted at edge N, we_mem_in SHALL be high in cycle N+1, done in N+2, and cmd_ready 1 in N+3.
REQ-030 Latency: with an OP accepted at edge N, the read SHALL occur in N+1, exec in N+2, we_resultado in N+3, done in N+4, and cmd_ready 1 in N+5.
REQ-031 we_mem_in and we_resultado SHALL never be 1 in the same cycle.
REQ-032 cmd_valid while cmd_ready=0 SHALL be ignored and SHALL not alter latched fields; the requester holds it.
REQ-033 All outputs SHALL be decoded from the state register and latched command registers only (no input-to-output combinational path except cmd_ready, which depends only on state and rst).
REQ-034 Opcode values 0..7 SHALL be passed through unchanged; address 0x000 and address 0x1FF SHALL be treated as legal.

Reset
REQ-035 While rst=1, the FSM SHALL be in IDLE and cmd_ready=0.
REQ-036 Reset SHALL clear cs, we_mem_in, we_resultado, done, enderecoA, enderecoB, endereco_saida, dado_in, opcode, res_data, cmd_count and all latched fields to 0.
REQ-037 Reset asserted in any state SHALL abort the command immediately (no write strobe, no done pulse, no count increment), and the first cmd_ready=1 SHALL appear in the first cycle after rst deasserts.

Structure
REQ-038 A shared package ctrl_mem_pkg SHALL hold ADDR_W=9, DATA_W=8, OP_W=3, the CMD_LOAD/CMD_OP encodings and the state encoding.
REQ-039 There SHALL be no sub-module; the FSM, latch registers and counter SHALL reside in ctrl_mem_ula.

Verification
REQ-040 LOAD dst=0x001, data=0x04 accepted at edge N -> cs=1, we_mem_in=1, endereco_saida=0x001, dado_in=0x04 in N+1; done in N+2; cmd_count=1.
REQ-041 OP opcode=000, a=0x008, b=0x009, dst=0x002, with s_ula=0x0C in EXEC -> enderecoA=0x008, enderecoB=0x009 in N+1..N+3; we_resultado=1 with endereco_saida=0x002 in N+3; res_data=0x0C; done in N+4.
REQ-042 cmd_valid held continuously with alternating LOAD/OP commands -> accepts spaced exactly 3 and 5 cycles; cmd_* changes while busy have no effect.
REQ-043 rst pulsed during WRITE of an OP -> we_resultado drops immediately; no done pulse; cmd_count unchanged from 0 after reset; next command accepted normally.
REQ-044 256 back-to-back LOADs -> cmd_count reads 255 then wraps to 0; the enables are never both high in any cycle (checked by assertion).
